// File: rtl/icache_responder_if.sv
// Bus bundle for icache_responder: the datapath fetch port (imemREN/imemaddr -> ihit/imemload, inval)
// and the memory-control fill port (iREN/iaddr <- iwait/iload).
interface icache_responder_if #(
  parameter int WORD_W = 32
) ();
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              inval;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  modport slave (
    input  imemREN, imemaddr, inval, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, inval, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line instruction cache with a 0-cycle combinational hit path.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_responder #(
  parameter int NSETS  = 16,
  parameter int WORD_W = 32
) (
  input  logic                CLK,
  input  logic                RST,
  icache_responder_if.slave   bus,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);
  localparam int IDX   = $clog2(NSETS);
  localparam int TAG_W = WORD_W - 2 - IDX;

  typedef enum logic [0:0] {IDLE = 1'b0, FETCH = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [NSETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [NSETS];
  logic [WORD_W-1:0] data_q [NSETS];
  logic [WORD_W-1:0] fetch_addr_q, fetch_addr_d;

  logic [IDX-1:0]    req_idx_s, fill_idx_s;
  logic [TAG_W-1:0]  req_tag_s, fill_tag_s;
  logic              idle_hit_s, miss_s, fill_s, fill_match_s;

  assign req_idx_s    = bus.imemaddr[IDX+1:2];
  assign req_tag_s    = bus.imemaddr[WORD_W-1:IDX+2];
  assign fill_idx_s   = fetch_addr_q[IDX+1:2];
  assign fill_tag_s   = fetch_addr_q[WORD_W-1:IDX+2];
  // inval masks the lookup in the same cycle it clears the valid bits
  assign idle_hit_s   = (state_q == IDLE) && bus.imemREN && !bus.inval &&
                        valid_q[req_idx_s] && (tag_q[req_idx_s] == req_tag_s);
  assign miss_s       = (state_q == IDLE) && bus.imemREN && !idle_hit_s;
  assign fill_s       = (state_q == FETCH) && !bus.iwait;
  assign fill_match_s = bus.imemREN && !bus.inval &&
                        (bus.imemaddr[WORD_W-1:2] == fetch_addr_q[WORD_W-1:2]);

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    valid_d      = valid_q;
    bus.ihit     = 1'b0;
    bus.imemload = {WORD_W{1'b0}};
    bus.iREN     = 1'b0;
    bus.iaddr    = {WORD_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (idle_hit_s) begin
          bus.ihit     = 1'b1;
          bus.imemload = data_q[req_idx_s];
        end else if (miss_s) begin
          fetch_addr_d = {bus.imemaddr[WORD_W-1:2], 2'b00};
          state_d      = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = fetch_addr_q;
        if (fill_s) begin
          valid_d[fill_idx_s] = 1'b1;
          state_d             = IDLE;
          if (fill_match_s) begin
            bus.ihit     = 1'b1;
            bus.imemload = bus.iload;
          end else begin
            bus.ihit = 1'b0;
          end
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    // invalidate wins over a coincident fill
    if (bus.inval) begin
      valid_d = {NSETS{1'b0}};
    end else begin
      valid_d = valid_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      valid_q      <= {NSETS{1'b0}};
      fetch_addr_q <= {WORD_W{1'b0}};
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  // Tag/data storage is left unreset; valid_q alone qualifies it
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      data_q[fill_idx_s] <= bus.iload;
      tag_q[fill_idx_s]  <= fill_tag_s;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      if (idle_hit_s) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (miss_s) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif
endmodule

// File: tb/tb_icache_responder.sv
// Directed self-checking bench for icache_responder: reset, cold/conflict misses, invalidate,
// mid-fetch redirect, reset mid-fetch and the optional statistics counters.
module tb_icache_responder;
  logic        clk;
  logic        rst;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  int          vec_cnt;
  int          err_cnt;

  icache_responder_if #(.WORD_W(32)) bus ();

  icache_responder #(.NSETS(16), .WORD_W(32)) dut (
    .CLK        (clk),
    .RST        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss in IDLE, nwait busy cycles, then a fill that returns data to the same address
  task automatic do_miss(input logic [31:0] addr, input int nwait, input logic [31:0] data);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.iwait    = 1'b1;
    @(negedge clk);
    check("miss_ihit", {31'd0, bus.ihit}, 32'd0);
    check("miss_iren", {31'd0, bus.iREN}, 32'd0);
    step();
    for (int i = 0; i < nwait; i++) begin
      @(negedge clk);
      check("wait_iren", {31'd0, bus.iREN}, 32'd1);
      check("wait_iaddr", bus.iaddr, {addr[31:2], 2'b00});
      check("wait_ihit", {31'd0, bus.ihit}, 32'd0);
      step();
    end
    bus.iwait = 1'b0;
    bus.iload = data;
    @(negedge clk);
    check("fill_iaddr", bus.iaddr, {addr[31:2], 2'b00});
    check("fill_ihit", {31'd0, bus.ihit}, 32'd1);
    check("fill_load", bus.imemload, data);
    step();
    bus.iwait   = 1'b1;
    bus.imemREN = 1'b0;
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] data);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    @(negedge clk);
    check("hit_ihit", {31'd0, bus.ihit}, 32'd1);
    check("hit_load", bus.imemload, data);
    check("hit_iren", {31'd0, bus.iREN}, 32'd0);
    step();
    bus.imemREN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [31:0] exp_hits;
    logic [31:0] exp_miss;
    vec_cnt      = 0;
    err_cnt      = 0;
    rst          = 1'b1;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0000_0000;
    bus.inval    = 1'b0;
    bus.iwait    = 1'b1;
    bus.iload    = 32'h0000_0000;
    step();
    bus.imemREN = 1'b1;
    @(negedge clk);
    check("rst_ihit", {31'd0, bus.ihit}, 32'd0);
    check("rst_iren", {31'd0, bus.iREN}, 32'd0);
    check("rst_iaddr", bus.iaddr, 32'h0000_0000);
    check("rst_load", bus.imemload, 32'h0000_0000);
    check("rst_hitcnt", hit_count, 32'd0);
    check("rst_misscnt", miss_count, 32'd0);
    step();
    rst = 1'b0;

    // cold miss at 0x0, then 0x40 with three busy cycles
    do_miss(32'h0000_0000, 0, 32'h1111_1111);
    do_miss(32'h0000_0040, 3, 32'hDEAD_BEEF);
    do_hit(32'h0000_0040, 32'hDEAD_BEEF);

    // conflict on index 0: 0x80 evicts 0x40, then byte address 0x42 hits the refilled line
    do_miss(32'h0000_0080, 0, 32'h8080_8080);
    do_hit(32'h0000_0080, 32'h8080_8080);
    do_miss(32'h0000_0040, 1, 32'hDEAD_BEEF);
    do_hit(32'h0000_0042, 32'hDEAD_BEEF);

    // invalidate coincident with the fill of 0x100 wipes every line
    do_miss(32'h0000_0044, 0, 32'h4444_4444);
    do_hit(32'h0000_0044, 32'h4444_4444);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0100;
    step();
    bus.iwait = 1'b0;
    bus.iload = 32'h0100_0100;
    bus.inval = 1'b1;
    @(negedge clk);
    check("inval_ihit", {31'd0, bus.ihit}, 32'd0);
    check("inval_iren", {31'd0, bus.iREN}, 32'd1);
    step();
    bus.inval   = 1'b0;
    bus.iwait   = 1'b1;
    bus.imemREN = 1'b0;
    do_miss(32'h0000_0100, 0, 32'h0100_0100);
    do_miss(32'h0000_0044, 0, 32'h4444_4444);
    do_miss(32'h0000_0040, 0, 32'hDEAD_BEEF);

    // redirect during a fetch: fill of 0x10 completes without a hit
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0010;
    step();
    bus.imemaddr = 32'h0000_0020;
    @(negedge clk);
    check("redir_iaddr", bus.iaddr, 32'h0000_0010);
    step();
    bus.iwait = 1'b0;
    bus.iload = 32'h1010_1010;
    @(negedge clk);
    check("redir_ihit", {31'd0, bus.ihit}, 32'd0);
    check("redir_fill_iaddr", bus.iaddr, 32'h0000_0010);
    step();
    bus.iwait   = 1'b1;
    bus.imemREN = 1'b0;
    do_hit(32'h0000_0010, 32'h1010_1010);
    do_miss(32'h0000_0020, 0, 32'h2020_2020);

`ifdef ICACHE_STATS_EN
    exp_hits = 32'd5;
    exp_miss = 32'd11;
`else
    exp_hits = 32'd0;
    exp_miss = 32'd0;
`endif
    @(negedge clk);
    check("stat_hits", hit_count, exp_hits);
    check("stat_miss", miss_count, exp_miss);

    // asynchronous reset in the middle of a fetch
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0200;
    step();
    @(negedge clk);
    check("pre_rst_iren", {31'd0, bus.iREN}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_iren", {31'd0, bus.iREN}, 32'd0);
    check("async_rst_iaddr", bus.iaddr, 32'h0000_0000);
    check("async_rst_hitcnt", hit_count, 32'd0);
    bus.imemREN = 1'b0;
    step();
    rst = 1'b0;
    do_miss(32'h0000_0010, 0, 32'h1010_1010);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
